// File: rtl/mem_pkg.sv
// Shared constants and types for the load/store data memory controller.
package mem_pkg;

    // RISC-V load/store width codes (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Legal read-latency range and the counter width that covers it
    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 8;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / replicated store data, load lane
// selection with sign/zero extension, and width/alignment fault detection.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        fault_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane extraction from the read word, independent of width
    always_comb begin
        byte_sel = rword_i[{addr_i, 3'b000} +: 8];
        half_sel = addr_i[1] ? rword_i[31:16] : rword_i[15:0];
    end

    // Width decode; a faulting access gets no byte enables and zero load data
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
        fault_o = 1'b0;
        case (funct3_i)
            F3_B: begin
                be_o    = 4'b0001 << addr_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H: begin
                fault_o = addr_i[0];
                be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{half_sel[15]}}, half_sel};
            end
            F3_W: begin
                fault_o = (addr_i != 2'b00);
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rword_i;
            end
            F3_BU: begin
                // unsigned widths have no store encoding
                fault_o = we_i;
                be_o    = 4'b0001 << addr_i;
                rdata_o = {24'h0, byte_sel};
            end
            F3_HU: begin
                fault_o = we_i | addr_i[0];
                be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                rdata_o = {16'h0, half_sel};
            end
            default: begin
                fault_o = 1'b1;
            end
        endcase
        if (fault_o) begin
            be_o    = 4'b0000;
            rdata_o = 32'h0;
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with request/response handshake and a fixed,
// parametrised read latency. One request in flight; stores commit at accept.
module data_memory_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned N   = 12,
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int unsigned DEPTH = 2 ** N;

    logic [31:0]      mem_q [DEPTH];
    logic [N-1:0]     idx;
    logic [31:0]      rword;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_rdata_q, pend_rdata_d;
    logic             pend_fault_q, pend_fault_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_fault_q, rsp_fault_d;

    logic             accept;
    logic             wr_en;
    logic [31:0]      new_rdata;
    logic [3:0]       be;
    logic [31:0]      st_word;
    logic [31:0]      ld_word;
    logic             fault;

    // Address bits above the array are deliberately ignored
    if (N < 30) begin : g_unused_addr
        logic unused_addr_hi;
        assign unused_addr_hi = ^req_addr[31:N+2];
    end

    assign idx   = req_addr[N+1:2];
    assign rword = mem_q[idx];

    mem_lane_align u_align (
        .addr_i   (req_addr[1:0]),
        .funct3_i (req_funct3),
        .we_i     (req_we),
        .wdata_i  (req_wdata),
        .rword_i  (rword),
        .be_o     (be),
        .wdata_o  (st_word),
        .rdata_o  (ld_word),
        .fault_o  (fault)
    );

    // Ready when idle or while the current response is being delivered
    always_comb begin
        req_ready = ~rst & ((state_q == IDLE) | (state_q == RESP));
        accept    = req_valid & req_ready;
        wr_en     = accept & req_we & ~fault;
        new_rdata = req_we ? 32'h0 : ld_word;
    end

    // Next-state, latency counter and response staging
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_rdata_d = pend_rdata_q;
        pend_fault_d = pend_fault_q;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    pend_rdata_d = new_rdata;
                    pend_fault_d = fault;
                    if (LAT > 1) begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LAT - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // With LAT == 1 the response comes straight from the accepted request
        rsp_valid_d = (state_d == RESP);
        rsp_rdata_d = 32'h0;
        rsp_fault_d = 1'b0;
        if (state_d == RESP) begin
            rsp_rdata_d = accept ? new_rdata : pend_rdata_q;
            rsp_fault_d = accept ? fault     : pend_fault_q;
        end
    end

    // Control and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pend_rdata_q <= 32'h0;
            pend_fault_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'h0;
            rsp_fault_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_rdata_q <= pend_rdata_d;
            pend_fault_q <= pend_fault_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_fault_q  <= rsp_fault_d;
        end
    end

    // Storage array with per-byte write enables; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= st_word[8*b +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: one LAT=1 and one LAT=4 instance, scenario tasks in sequence.
module tb_data_memory_ctrl;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LAT = 1 instance signals
    logic        a_rst, a_valid, a_ready, a_we, a_rsp_valid, a_rsp_fault;
    logic [31:0] a_addr, a_wdata, a_rsp_rdata;
    logic [2:0]  a_f3;
    // LAT = 4 instance signals
    logic        b_rst, b_valid, b_ready, b_we, b_rsp_valid, b_rsp_fault;
    logic [31:0] b_addr, b_wdata, b_rsp_rdata;
    logic [2:0]  b_f3;

    int checks = 0;
    int errors = 0;

    // Results of the most recent transaction
    int          r_lat;
    logic [31:0] r_rd, r_prd;
    logic        r_flt, r_pv, r_pf;

    data_memory_ctrl #(.N(12), .LAT(1)) u_dut1 (
        .clk(clk), .rst(a_rst), .req_valid(a_valid), .req_ready(a_ready),
        .req_addr(a_addr), .req_funct3(a_f3), .req_we(a_we), .req_wdata(a_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_fault(a_rsp_fault)
    );

    data_memory_ctrl #(.N(12), .LAT(4)) u_dut4 (
        .clk(clk), .rst(b_rst), .req_valid(b_valid), .req_ready(b_ready),
        .req_addr(b_addr), .req_funct3(b_f3), .req_we(b_we), .req_wdata(b_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_fault(b_rsp_fault)
    );

    // One request on instance sel (0: LAT=1, 1: LAT=4); latency counted in
    // cycles from the accepting cycle to the response cycle
    task automatic xact(input bit sel, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
        int n;
        if (sel) begin
            b_valid = 1'b1; b_we = we; b_f3 = f3; b_addr = addr; b_wdata = wd;
        end else begin
            a_valid = 1'b1; a_we = we; a_f3 = f3; a_addr = addr; a_wdata = wd;
        end
        n = 0;
        while (((sel ? b_ready : a_ready) !== 1'b1) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        r_lat = 1;
        while (((sel ? b_rsp_valid : a_rsp_valid) !== 1'b1) && r_lat < 20) begin
            @(posedge clk); #1; r_lat++;
        end
        r_rd  = sel ? b_rsp_rdata : a_rsp_rdata;
        r_flt = sel ? b_rsp_fault : a_rsp_fault;
        @(posedge clk); #1;
        r_pv  = sel ? b_rsp_valid : a_rsp_valid;
        r_pf  = sel ? b_rsp_fault : a_rsp_fault;
        r_prd = sel ? b_rsp_rdata : a_rsp_rdata;
    endtask

    task automatic test_reset;
        a_rst = 1'b1; b_rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1 got %b exp 0", a_ready); end
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL rst_ready4 got %b exp 0", b_ready); end
        checks++; if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b/%b exp 0/0", a_rsp_valid, b_rsp_valid); end
        checks++; if (a_rsp_rdata !== 32'h0 || b_rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h/%h exp 0/0", a_rsp_rdata, b_rsp_rdata); end
        checks++; if (a_rsp_fault !== 1'b0 || b_rsp_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b/%b exp 0/0", a_rsp_fault, b_rsp_fault); end
        a_rst = 1'b0; b_rst = 1'b0;
        #1;
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b/%b exp 1/1", a_ready, b_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_word;
        xact(1'b0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF);
        checks++; if (r_lat !== 1) begin errors++; $display("FAIL sw_latency got %0d exp 1", r_lat); end
        checks++; if (r_rd !== 32'h0 || r_flt !== 1'b0) begin errors++; $display("FAIL sw_rsp got %h/%b exp 0/0", r_rd, r_flt); end
        xact(1'b0, 1'b0, F3_W, 32'h10, 32'h0);
        checks++; if (r_lat !== 1) begin errors++; $display("FAIL lw_latency got %0d exp 1", r_lat); end
        checks++; if (r_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h exp deadbeef", r_rd); end
        checks++; if (r_flt !== 1'b0) begin errors++; $display("FAIL lw_fault got %b exp 0", r_flt); end
        checks++; if (r_pv !== 1'b0 || r_prd !== 32'h0) begin errors++; $display("FAIL lw_pulse got %b/%h exp 0/0", r_pv, r_prd); end
    endtask

    task automatic test_byte;
        xact(1'b0, 1'b1, F3_W, 32'h10, 32'h0);
        xact(1'b0, 1'b1, F3_B, 32'h11, 32'h000000A5);
        xact(1'b0, 1'b0, F3_W, 32'h10, 32'h0);
        checks++; if (r_rd !== 32'h0000A500) begin errors++; $display("FAIL sb_lw got %h exp 0000a500", r_rd); end
        xact(1'b0, 1'b0, F3_B, 32'h11, 32'h0);
        checks++; if (r_rd !== 32'hFFFFFFA5) begin errors++; $display("FAIL lb got %h exp ffffffa5", r_rd); end
        xact(1'b0, 1'b0, F3_BU, 32'h11, 32'h0);
        checks++; if (r_rd !== 32'h000000A5) begin errors++; $display("FAIL lbu got %h exp 000000a5", r_rd); end
        xact(1'b0, 1'b0, F3_B, 32'h10, 32'h0);
        checks++; if (r_rd !== 32'h0) begin errors++; $display("FAIL lb_lane0 got %h exp 0", r_rd); end
    endtask

    task automatic test_half;
        xact(1'b0, 1'b1, F3_W, 32'h20, 32'h0);
        xact(1'b0, 1'b1, F3_H, 32'h22, 32'h00008001);
        xact(1'b0, 1'b0, F3_H, 32'h22, 32'h0);
        checks++; if (r_rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh got %h exp ffff8001", r_rd); end
        xact(1'b0, 1'b0, F3_HU, 32'h22, 32'h0);
        checks++; if (r_rd !== 32'h00008001) begin errors++; $display("FAIL lhu got %h exp 00008001", r_rd); end
        xact(1'b0, 1'b0, F3_W, 32'h20, 32'h0);
        checks++; if (r_rd !== 32'h80010000) begin errors++; $display("FAIL sh_lw got %h exp 80010000", r_rd); end
    endtask

    task automatic test_faults;
        xact(1'b0, 1'b0, F3_H, 32'h23, 32'h0);
        checks++; if (r_flt !== 1'b1 || r_rd !== 32'h0) begin errors++; $display("FAIL lh_misalign got %b/%h exp 1/0", r_flt, r_rd); end
        checks++; if (r_pf !== 1'b0) begin errors++; $display("FAIL fault_pulse got %b exp 0", r_pf); end
        xact(1'b0, 1'b0, F3_W, 32'h22, 32'h0);
        checks++; if (r_flt !== 1'b1 || r_rd !== 32'h0) begin errors++; $display("FAIL lw_misalign got %b/%h exp 1/0", r_flt, r_rd); end
        xact(1'b0, 1'b0, 3'b011, 32'h20, 32'h0);
        checks++; if (r_flt !== 1'b1 || r_rd !== 32'h0) begin errors++; $display("FAIL f3_011 got %b/%h exp 1/0", r_flt, r_rd); end
        xact(1'b0, 1'b1, F3_W, 32'h22, 32'hFFFFFFFF);
        checks++; if (r_flt !== 1'b1) begin errors++; $display("FAIL sw_misalign got %b exp 1", r_flt); end
        xact(1'b0, 1'b1, F3_BU, 32'h20, 32'h000000FF);
        checks++; if (r_flt !== 1'b1) begin errors++; $display("FAIL store_bu got %b exp 1", r_flt); end
        xact(1'b0, 1'b0, F3_W, 32'h20, 32'h0);
        checks++; if (r_rd !== 32'h80010000 || r_flt !== 1'b0) begin errors++; $display("FAIL fault_nowrite got %h/%b exp 80010000/0", r_rd, r_flt); end
    endtask

    task automatic test_back_to_back;
        int k;
        int r;
        logic exp_rdy;
        logic exp_vld;
        logic [31:0] exp_d;
        xact(1'b1, 1'b1, F3_W, 32'h40, 32'h11111111);
        checks++; if (r_lat !== 4) begin errors++; $display("FAIL lat4_store got %0d exp 4", r_lat); end
        xact(1'b1, 1'b1, F3_W, 32'h44, 32'h22222222);
        xact(1'b1, 1'b1, F3_W, 32'h48, 32'h33333333);
        k = 0;
        r = 0;
        b_valid = 1'b1; b_we = 1'b0; b_f3 = F3_W; b_addr = 32'h40; b_wdata = 32'h0;
        for (int c = 0; c <= 12; c++) begin
            exp_rdy = (c % 4 == 0);
            exp_vld = (c == 4) || (c == 8) || (c == 12);
            checks++; if (b_ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready cyc %0d got %b exp %b", c, b_ready, exp_rdy); end
            checks++; if (b_rsp_valid !== exp_vld) begin errors++; $display("FAIL b2b_valid cyc %0d got %b exp %b", c, b_rsp_valid, exp_vld); end
            if (b_rsp_valid === 1'b1 && r < 3) begin
                exp_d = 32'h11111111 * 32'(r + 1);
                checks++; if (b_rsp_rdata !== exp_d) begin errors++; $display("FAIL b2b_rdata %0d got %h exp %h", r, b_rsp_rdata, exp_d); end
                r++;
            end
            if (b_ready === 1'b1 && b_valid === 1'b1) k++;
            @(posedge clk); #1;
            if (k >= 3) b_valid = 1'b0;
            else b_addr = 32'h40 + 32'(4 * k);
        end
        b_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic seen;
        b_valid = 1'b1; b_we = 1'b1; b_f3 = F3_W; b_addr = 32'h30; b_wdata = 32'h12345678;
        @(posedge clk); #1;
        b_valid = 1'b0;
        @(posedge clk); #1;
        b_rst = 1'b1;
        #1;
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", b_ready); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (b_rsp_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
            if (i == 1) b_rst = 1'b0;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_rst_drop got %b exp 0", seen); end
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready_after got %b exp 1", b_ready); end
        xact(1'b1, 1'b0, F3_W, 32'h30, 32'h0);
        checks++; if (r_lat !== 4) begin errors++; $display("FAIL mid_rst_lat got %0d exp 4", r_lat); end
        checks++; if (r_rd !== 32'h12345678 || r_flt !== 1'b0) begin errors++; $display("FAIL mid_rst_kept got %h/%b exp 12345678/0", r_rd, r_flt); end
    endtask

    initial begin
        a_rst = 1'b1; a_valid = 1'b0; a_we = 1'b0; a_f3 = F3_W; a_addr = 32'h0; a_wdata = 32'h0;
        b_rst = 1'b1; b_valid = 1'b0; b_we = 1'b0; b_f3 = F3_W; b_addr = 32'h0; b_wdata = 32'h0;
        #1;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_faults();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
